// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-command codes common with the master bit controller
// and the state encoding of the slave byte engine.
package i2c_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  localparam logic BUS_ACK  = 1'b0;
  localparam logic BUS_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_WR_DATA   = 4'd3,
    ST_WR_ACK    = 4'd4,
    ST_RD_LOAD   = 4'd5,
    ST_RD_DATA   = 4'd6,
    ST_RD_ACK    = 4'd7,
    ST_WAIT_STOP = 4'd8
  } slave_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus glitch filter for one open-drain bus line; emits
// the filtered level and one-cycle rise/fall flags.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic bus_line,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

  logic       sync_q1;
  logic       sync_q2;
  logic [2:0] cnt;

  // Idle bus is pulled high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_q1 <= bus_line;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_q2;
        rise  <= sync_q2;
        fall  <= ~sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_controller.sv
// I2C target byte engine: START/STOP detection, 7-bit address match, write-byte
// delivery with user ACK control, and read-byte fetch with SCL stretching.
module i2c_slave_controller
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  inout  wire        io_scl,
  inout  wire        io_sda,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_tx_req,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_nack,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_rw,
  output logic       o_busy,
  output logic [3:0] o_state
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start_det, stop_det;

  slave_state_e state, state_n;
  logic [3:0]   bit_cnt, bit_cnt_n;
  logic [7:0]   shift_q, shift_n;
  logic [7:0]   rx_data_q, rx_data_n;
  logic         rw_q, rw_n;
  logic         busy_q, busy_n;
  logic         sda_low_q, sda_low_n;
  logic         scl_low_q, scl_low_n;
  logic         ack_flag_q, ack_flag_n;
  logic         rx_valid_q, rx_valid_n;
  logic         nack_q, nack_n;
  logic         start_q, start_n;
  logic         stop_q, stop_n;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .bus_line (io_scl),
    .level    (scl_level),
    .rise     (scl_rise),
    .fall     (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .bus_line (io_sda),
    .level    (sda_level),
    .rise     (sda_rise),
    .fall     (sda_fall)
  );

  assign start_det = sda_fall & scl_level;
  assign stop_det  = sda_rise & scl_level;

  assign io_scl = scl_low_q ? 1'b0 : 1'bz;
  assign io_sda = sda_low_q ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_low_q  <= 1'b0;
      scl_low_q  <= 1'b0;
      ack_flag_q <= 1'b0;
      rx_valid_q <= 1'b0;
      nack_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift_q    <= shift_n;
      rx_data_q  <= rx_data_n;
      rw_q       <= rw_n;
      busy_q     <= busy_n;
      sda_low_q  <= sda_low_n;
      scl_low_q  <= scl_low_n;
      ack_flag_q <= ack_flag_n;
      rx_valid_q <= rx_valid_n;
      nack_q     <= nack_n;
      start_q    <= start_n;
      stop_q     <= stop_n;
    end
  end

  // START/STOP override any bit-level activity seen in the same cycle.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_q;
    rx_data_n  = rx_data_q;
    rw_n       = rw_q;
    busy_n     = busy_q;
    sda_low_n  = sda_low_q;
    scl_low_n  = scl_low_q;
    ack_flag_n = ack_flag_q;
    rx_valid_n = 1'b0;
    nack_n     = 1'b0;
    start_n    = 1'b0;
    stop_n     = 1'b0;

    if (stop_det) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      sda_low_n = 1'b0;
      scl_low_n = 1'b0;
      busy_n    = 1'b0;
      stop_n    = 1'b1;
    end else if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_low_n = 1'b0;
      scl_low_n = 1'b0;
      busy_n    = 1'b0;
      start_n   = 1'b1;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift_q[6:0], sda_level};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = '0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              rw_n      = shift_q[0];
              busy_n    = 1'b1;
              sda_low_n = 1'b1;
              state_n   = ST_ADDR_ACK;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_low_n = 1'b0;
            if (rw_q) begin
              scl_low_n = 1'b1;
              state_n   = ST_RD_LOAD;
            end else begin
              state_n = ST_WR_DATA;
            end
          end
        end

        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_n   = {shift_q[6:0], sda_level};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n  = '0;
            rx_data_n  = shift_q;
            rx_valid_n = 1'b1;
            ack_flag_n = i_rx_ready;
            sda_low_n  = i_rx_ready;
            state_n    = ST_WR_ACK;
          end
        end

        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_low_n = 1'b0;
            state_n   = ack_flag_q ? ST_WR_DATA : ST_WAIT_STOP;
          end
        end

        // SCL stays low until the user supplies a byte; bit 7 is put on SDA
        // one cycle before SCL is let go so it has setup time.
        ST_RD_LOAD: begin
          scl_low_n = 1'b1;
          if (i_tx_valid) begin
            shift_n   = i_tx_data;
            sda_low_n = ~i_tx_data[7];
            bit_cnt_n = '0;
            state_n   = ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (scl_low_q) begin
            scl_low_n = 1'b0;
          end
          if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              sda_low_n  = 1'b0;
              bit_cnt_n  = '0;
              ack_flag_n = 1'b0;
              state_n    = ST_RD_ACK;
            end else begin
              shift_n   = {shift_q[6:0], 1'b0};
              sda_low_n = ~shift_q[6];
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_level == BUS_ACK) begin
              ack_flag_n = 1'b1;
            end else begin
              nack_n  = 1'b1;
              state_n = ST_WAIT_STOP;
            end
          end else if (scl_fall && ack_flag_q) begin
            scl_low_n = 1'b1;
            state_n   = ST_RD_LOAD;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_tx_req   = (state == ST_RD_LOAD);
  assign o_nack     = nack_q;
  assign o_start    = start_q;
  assign o_stop     = stop_q;
  assign o_rw       = rw_q;
  assign o_busy     = busy_q;
  assign o_state    = state;

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Self-checking bench: a bit-level I2C master model drives the bus, a table of
// write transactions plus hand-written read/restart/reset/glitch sequences.
module tb_i2c_slave_controller;
  import i2c_pkg::*;

  localparam int LOW_HALF    = 10;
  localparam int HIGH_HALF   = 10;
  localparam int STRETCH_MAX = 500;

  typedef struct {
    logic [6:0]   addr;
    logic [7:0]   data;
    logic         rx_ready;
    logic         exp_addr_ack;
    slave_state_e exp_state;
  } wr_vec_t;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_ready = 1'b1;
  logic [7:0] i_tx_data = 8'h00;
  logic       i_tx_valid = 1'b0;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, o_tx_req, o_nack, o_start, o_stop, o_rw, o_busy;
  logic [3:0] o_state;

  wire  scl;
  wire  sda;
  logic m_scl_low = 1'b0;
  logic m_sda_low = 1'b0;

  pullup (scl);
  pullup (sda);
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int nack_cnt = 0;
  int rx_cnt = 0;
  int last_stretch = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_byte;
  wr_vec_t    vecs[5];

  i2c_slave_controller #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .io_scl     (scl),
    .io_sda     (sda),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .i_rx_ready (i_rx_ready),
    .o_tx_req   (o_tx_req),
    .i_tx_data  (i_tx_data),
    .i_tx_valid (i_tx_valid),
    .o_nack     (o_nack),
    .o_start    (o_start),
    .o_stop     (o_stop),
    .o_rw       (o_rw),
    .o_busy     (o_busy),
    .o_state    (o_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulse counters and the received-byte scoreboard, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_start) start_cnt++;
      if (o_stop)  stop_cnt++;
      if (o_nack)  nack_cnt++;
      if (o_rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rx_unexpected: got 0x%0h, expected no byte", o_rx_data);
        end else begin
          exp_byte = exp_rx.pop_front();
          checkOutput("rx_data", {24'd0, o_rx_data}, {24'd0, exp_byte});
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One SCL clock: SDA set mid-low, SCL released (honouring stretch), SDA sampled mid-high.
  task automatic busBit(input logic drv, output logic smp);
    int n;
    n = 0;
    waitCycles(LOW_HALF);
    m_sda_low = ~drv;
    waitCycles(LOW_HALF);
    m_scl_low = 1'b0;
    while (scl !== 1'b1 && n < STRETCH_MAX) begin
      waitCycles(1);
      n++;
    end
    if (n >= STRETCH_MAX) checkOutput("scl_release_timeout", {31'd0, scl}, 32'd1);
    last_stretch = n;
    waitCycles(HIGH_HALF);
    smp = sda;
    waitCycles(HIGH_HALF);
    m_scl_low = 1'b1;
  endtask

  task automatic busStart();
    m_sda_low = 1'b1;
    waitCycles(HIGH_HALF);
    m_scl_low = 1'b1;
  endtask

  task automatic busRepStart();
    waitCycles(LOW_HALF);
    m_sda_low = 1'b0;
    waitCycles(LOW_HALF);
    m_scl_low = 1'b0;
    waitCycles(HIGH_HALF);
    m_sda_low = 1'b1;
    waitCycles(HIGH_HALF);
    m_scl_low = 1'b1;
  endtask

  task automatic busStop();
    waitCycles(LOW_HALF);
    m_sda_low = 1'b1;
    waitCycles(LOW_HALF);
    m_scl_low = 1'b0;
    waitCycles(HIGH_HALF);
    m_sda_low = 1'b0;
    waitCycles(2 * HIGH_HALF);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) busBit(b[i], dummy);
    busBit(1'b1, ack);
  endtask

  task automatic readByte(output logic [7:0] b, input logic nack_bit, output int low_first);
    logic s;
    logic dummy;
    low_first = 0;
    for (int i = 7; i >= 0; i--) begin
      busBit(1'b1, s);
      b[i] = s;
      if (i == 7) low_first = 2 * LOW_HALF + last_stretch;
    end
    busBit(nack_bit, dummy);
  endtask

  // User side of a read: wait for the request, then present one byte after a delay.
  task automatic respond(input logic [7:0] d, input int delay);
    int n;
    n = 0;
    while (!o_tx_req && n < 2000) begin
      waitCycles(1);
      n++;
    end
    if (!o_tx_req) checkOutput("tx_req_timeout", {31'd0, o_tx_req}, 32'd1);
    waitCycles(delay);
    i_tx_data  = d;
    i_tx_valid = 1'b1;
    waitCycles(1);
    i_tx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input wr_vec_t v);
    logic ack;
    int   rx_before;
    int   stop_before;
    logic data_acked;
    rx_before   = rx_cnt;
    stop_before = stop_cnt;
    data_acked  = v.exp_addr_ack && v.rx_ready;
    busStart();
    writeByte({v.addr, 1'b0}, ack);
    checkOutput("addr_ack", {31'd0, ack}, v.exp_addr_ack ? 32'd0 : 32'd1);
    checkOutput("busy_after_addr", {31'd0, o_busy}, {31'd0, v.exp_addr_ack});
    i_rx_ready = v.rx_ready;
    if (v.exp_addr_ack) exp_rx.push_back(v.data);
    writeByte(v.data, ack);
    checkOutput("data_ack", {31'd0, ack}, data_acked ? 32'd0 : 32'd1);
    waitCycles(10);
    checkOutput("state_after_byte", {28'd0, o_state}, {28'd0, v.exp_state});
    if (!data_acked) begin
      writeByte(8'hFF, ack);
      checkOutput("ignored_byte_ack", {31'd0, ack}, 32'd1);
    end
    busStop();
    checkOutput("state_after_stop", {28'd0, o_state}, {28'd0, ST_IDLE});
    checkOutput("busy_after_stop", {31'd0, o_busy}, 32'd0);
    checkOutput("stop_pulses", stop_cnt - stop_before, 32'd1);
    checkOutput("rx_valid_pulses", rx_cnt - rx_before, v.exp_addr_ack ? 32'd1 : 32'd0);
    i_rx_ready = 1'b1;
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         low_first;
    int         n;
    int         start_before;
    int         rx_before;
    int         nack_before;

    vecs[0] = '{7'h50, 8'hA5, 1'b1, 1'b1, ST_WR_DATA};
    vecs[1] = '{7'h51, 8'h3C, 1'b1, 1'b0, ST_WAIT_STOP};
    vecs[2] = '{7'h50, 8'h00, 1'b0, 1'b1, ST_WAIT_STOP};
    vecs[3] = '{7'h50, 8'hFF, 1'b1, 1'b1, ST_WR_DATA};
    vecs[4] = '{7'h00, 8'h5A, 1'b1, 1'b0, ST_WAIT_STOP};

    waitCycles(5);
    checkOutput("reset_state", {28'd0, o_state}, {28'd0, ST_IDLE});
    checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("reset_rw", {31'd0, o_rw}, 32'd0);
    checkOutput("reset_tx_req", {31'd0, o_tx_req}, 32'd0);
    checkOutput("reset_rx_data", {24'd0, o_rx_data}, 32'd0);
    checkOutput("reset_pulses", {28'd0, o_rx_valid, o_nack, o_start, o_stop}, 32'd0);
    checkOutput("reset_lines", {30'd0, scl, sda}, 32'd3);
    i_reset = 1'b0;
    waitCycles(10);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] write vector %0d addr 0x%0h data 0x%0h", i, vecs[i].addr, vecs[i].data);
      applyStimulus(vecs[i]);
    end

    // Read with a 50-cycle late user byte, master NACKs it.
    $display("[TB] read with clock stretch");
    nack_before = nack_cnt;
    busStart();
    writeByte({7'h50, 1'b1}, ack);
    checkOutput("rd_addr_ack", {31'd0, ack}, 32'd0);
    checkOutput("rd_rw", {31'd0, o_rw}, 32'd1);
    fork
      readByte(rd, 1'b1, low_first);
      respond(8'h3C, 50);
    join
    checkOutput("rd_data", {24'd0, rd}, 32'h3C);
    checkOutput("stretch_ge_50", {31'd0, low_first >= 50}, 32'd1);
    checkOutput("nack_pulses", nack_cnt - nack_before, 32'd1);
    waitCycles(10);
    checkOutput("state_after_nack", {28'd0, o_state}, {28'd0, ST_WAIT_STOP});
    checkOutput("sda_released_after_nack", {31'd0, sda}, 32'd1);
    checkOutput("tx_req_after_nack", {31'd0, o_tx_req}, 32'd0);
    busStop();
    checkOutput("rd_state_after_stop", {28'd0, o_state}, {28'd0, ST_IDLE});

    // Partial write, repeated START into a read, then reset during RD_DATA.
    $display("[TB] repeated start and reset in read");
    start_before = start_cnt;
    rx_before    = rx_cnt;
    busStart();
    writeByte({7'h50, 1'b0}, ack);
    checkOutput("rs_addr_ack", {31'd0, ack}, 32'd0);
    busBit(1'b1, ack);
    busBit(1'b0, ack);
    busBit(1'b1, ack);
    busBit(1'b1, ack);
    busRepStart();
    writeByte({7'h50, 1'b1}, ack);
    checkOutput("rs_read_addr_ack", {31'd0, ack}, 32'd0);
    waitCycles(10);
    checkOutput("rs_start_pulses", start_cnt - start_before, 32'd2);
    checkOutput("rs_no_rx_valid", rx_cnt - rx_before, 32'd0);
    checkOutput("rs_rw", {31'd0, o_rw}, 32'd1);
    checkOutput("rs_tx_req", {31'd0, o_tx_req}, 32'd1);
    respond(8'h00, 5);
    waitCycles(LOW_HALF);
    m_scl_low = 1'b0;
    n = 0;
    while (scl !== 1'b1 && n < STRETCH_MAX) begin
      waitCycles(1);
      n++;
    end
    if (n >= STRETCH_MAX) checkOutput("rs_scl_timeout", {31'd0, scl}, 32'd1);
    waitCycles(5);
    checkOutput("rd_bit7_driven", {31'd0, sda}, 32'd0);
    checkOutput("rd_data_state", {28'd0, o_state}, {28'd0, ST_RD_DATA});
    i_reset = 1'b1;
    waitCycles(1);
    checkOutput("reset_mid_lines", {30'd0, scl, sda}, 32'd3);
    checkOutput("reset_mid_state", {28'd0, o_state}, {28'd0, ST_IDLE});
    checkOutput("reset_mid_busy", {31'd0, o_busy}, 32'd0);
    waitCycles(2);
    i_reset = 1'b0;
    waitCycles(20);

    // Short SDA glitches while SCL is high must not look like a START.
    $display("[TB] sda glitch in idle");
    start_before = start_cnt;
    m_sda_low = 1'b1;
    waitCycles(1);
    m_sda_low = 1'b0;
    waitCycles(20);
    checkOutput("glitch1_no_start", start_cnt - start_before, 32'd0);
    m_sda_low = 1'b1;
    waitCycles(2);
    m_sda_low = 1'b0;
    waitCycles(20);
    checkOutput("glitch2_no_start", start_cnt - start_before, 32'd0);
    checkOutput("glitch_state", {28'd0, o_state}, {28'd0, ST_IDLE});

    checkOutput("rx_queue_empty", exp_rx.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_controller.md
Name: i2c_slave_controller

Overview:
I2C target (slave) byte engine. It is the responder counterpart of the team's I2C master bit controller and sits on the same open-drain SCL/SDA pair. It oversamples and filters the bus, detects START, repeated START and STOP, matches a 7-bit address, and ACKs the address. It then delivers written bytes to the user side, or fetches read bytes from the user side. While a read byte is pending, it stretches SCL.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this target responds to
FILTER_LEN, 3, consecutive identical samples required before a filtered SCL/SDA level changes (1..7)

Ports:
i_clk  input  1  system clock; must be at least 20x the SCL frequency
i_reset  input  1  synchronous active-high reset
io_scl  inout  1  open-drain SCL; driven only to 0 (clock stretch), else z
io_sda  inout  1  open-drain SDA; driven only to 0, else z
o_rx_data  output  8  last byte written by the master
o_rx_valid  output  1  one-cycle pulse; o_rx_data is valid
i_rx_ready  input  1  sampled at 8th-bit completion of a write byte; 1 = ACK, 0 = NACK
o_tx_req  output  1  level; high while a read byte is needed
i_tx_data  input  8  read byte, captured when i_tx_valid & o_tx_req
i_tx_valid  input  1  user supplies i_tx_data
o_nack  output  1  one-cycle pulse; master NACKed a read byte
o_start  output  1  one-cycle pulse on filtered START or repeated START
o_stop  output  1  one-cycle pulse on filtered STOP
o_rw  output  1  R/W bit of the current transaction (1 = read)
o_busy  output  1  high from an address match until STOP or START
o_state  output  4  current FSM state code

Behaviour:
- Input path: two-flop synchronizer per line, then a glitch filter. The filtered level flips only after FILTER_LEN equal samples. Edge flags are 1-cycle pulses derived from the filtered levels. Bus-to-flag latency is 2+FILTER_LEN cycles.
- START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high. Both are valid in any state and take priority over bit processing in the same cycle.
- Sampling and driving: SDA is sampled on the filtered SCL rising edge. The SDA drive changes only on the filtered SCL falling edge.
- Reset values: all outputs 0, io_scl/io_sda released (z), state IDLE, bit counter 0, o_rw 0.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE: on START go to ADDR; pulse o_start; clear the bit counter.
- ADDR: shift in 8 bits MSB first. On the 8th-bit SCL fall:
  - If bits[7:1]==SLAVE_ADDR: latch o_rw, set o_busy, drive SDA low, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP with SDA released.
- ADDR_ACK: on the next SCL fall, release SDA. If o_rw=0 go to WR_DATA; if o_rw=1 go to RD_LOAD.
- WR_DATA: shift in 8 bits. On the 8th-bit SCL fall:
  - Update o_rx_data and pulse o_rx_valid.
  - Sample i_rx_ready: 1 drives SDA low (ACK), 0 leaves SDA released (NACK).
  - Go to WR_ACK.
- WR_ACK: on SCL fall, release SDA. After ACK go to WR_DATA; after NACK go to WAIT_STOP.
- RD_LOAD: hold io_scl low and assert o_tx_req. On i_tx_valid, load the shift register, drive bit 7, release SCL the next cycle, and go to RD_DATA.
- RD_DATA: drive the shift register MSB; shift on each SCL fall. After the 8th fall, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on SCL rise.
  - 0 (ACK): go to RD_LOAD on the following SCL fall.
  - 1 (NACK): pulse o_nack and go to WAIT_STOP.
- WAIT_STOP: both lines released; wait for STOP (go to IDLE) or START (go to ADDR).
- STOP in any state: release both lines, clear o_busy, pulse o_stop, go to IDLE.
- START in any non-IDLE state (repeated START): release both lines, clear o_busy, pulse o_start, go to ADDR. No o_rx_valid is emitted for a partial byte.
- SCL stretching is used only in RD_LOAD. The slave never stretches during write bytes.
- General-call address (0x00) is not recognized.
- Reset asserted mid-transaction releases both lines on the next clock edge and returns to IDLE; a partial byte is discarded.

Decomposition:
- Shared package i2c_pkg: the bus-command and state localparams shared with the master controller, plus the state encoding of this block.
- One sub-module, i2c_line_filter: synchronizer, glitch filter and rise/fall flags. It is instantiated twice, once for SCL and once for SDA.

Test Plan:
- Master writes address 0x50+W, then 0xA5, then STOP, with i_rx_ready=1 → SDA low during both 9th clocks, one o_rx_valid with o_rx_data=0xA5, o_stop pulse, o_busy 0 afterwards.
- Master sends address 0x51+W → SDA never driven, o_busy stays 0, no o_rx_valid, return to IDLE on STOP.
- Master sends 0x50+R; user raises i_tx_valid 50 cycles after o_tx_req with 0x3C → SCL held low for ≥50 cycles, then SDA carries 0,0,1,1,1,1,0,0; master NACK gives an o_nack pulse and SDA released.
- Write 0x50+W, 4 data bits, then repeated START and 0x50+R → no o_rx_valid, o_start pulses twice, o_rw=1, o_tx_req asserts.
- Write with i_rx_ready=0 on the first byte → SDA released during the 9th clock, state WAIT_STOP, later data bits ignored.
- 1-cycle SDA glitch while SCL is high in IDLE (FILTER_LEN=3) → no o_start. Reset asserted during RD_DATA → io_scl/io_sda released on the next clock, o_state=IDLE.
